mem_responder: RTL



---
 rtl/mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: services one read or write request at a time from an
// internal word array after a fixed number of wait cycles, then pulses ready.
module mem_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] RD_LAT_C = 4'(RD_LATENCY);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    mem_we_s;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Next-state logic: accept requests only in IDLE, count down the wait, then respond.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          if (we) begin
            cnt_d   = WR_LAT_C;
            state_d = WR_WAIT;
          end else begin
            cnt_d   = RD_LAT_C;
            state_d = RD_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = mem_q[addr_q];
          state_d = RESP;
        end
      end
      WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we_s = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered copies of the decoded next state.
    ready_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  // Control and output registers; reset aborts any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Word array: not cleared by reset, and a write pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
